// File: rtl/ov7670_capture.sv
`timescale 1ns/1ps
// ov7670_capture -- captures the OV7670 RGB444 (xR GB) byte stream into a row-major frame buffer.
// Optional macro CAPTURE_DECIMATE_EN: 2*H_ACTIVE x 2*V_ACTIVE input, every other pixel of every other line stored.
module ov7670_capture #(
    parameter int H_ACTIVE = 160,
    parameter int V_ACTIVE = 120,
    parameter int ADDR_W   = 16
) (
    input  logic              CLK_CAM_I,
    input  logic              RST_N_I,
    input  logic              ENABLE_I,
    input  logic              VSYNC_I,
    input  logic              HREF_I,
    input  logic [7:0]        DATA_I,
    output logic              WR_EN_O,
    output logic [ADDR_W-1:0] WR_ADDR_O,
    output logic [11:0]       WR_DATA_O,
    output logic              FRAME_DONE_O,
    output logic              BUSY_O
);

`ifdef CAPTURE_DECIMATE_EN
    localparam int SCALE = 2;
`else
    localparam int SCALE = 1;
`endif

    // Counters see raw input indices and saturate, so oversize lines/frames can never wrap back into range.
    localparam int PIX_W  = $clog2(4 * SCALE * H_ACTIVE + 1);
    localparam int LINE_W = $clog2(4 * SCALE * V_ACTIVE + 1);
    localparam logic [PIX_W-1:0]  PIX_LIM  = PIX_W'(SCALE * H_ACTIVE);
    localparam logic [LINE_W-1:0] LINE_LIM = LINE_W'(SCALE * V_ACTIVE);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        CAPTURE    = 2'd2
    } state_t;

    state_t             state_q, state_n;
    logic               vsync_q, vsync_d, href_q, href_d;
    logic [7:0]         data_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [PIX_W-1:0]   pix_cnt_q;
    logic [LINE_W-1:0]  line_cnt_q;
    logic               phase_q;
    logic [3:0]         red_q;
    logic               vsync_rise, vsync_fall, href_rise, href_fall;
    logic               cap_entry, cap_exit, cur_phase, keep_sel, do_write;

    // NOTE: sequential state always uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK_CAM_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            vsync_q <= 1'b0;
            vsync_d <= 1'b0;
            href_q  <= 1'b0;
            href_d  <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            vsync_q <= VSYNC_I;
            vsync_d <= vsync_q;
            href_q  <= HREF_I;
            href_d  <= href_q;
            data_q  <= DATA_I;
        end
    end

    assign vsync_rise = vsync_q & ~vsync_d;
    assign vsync_fall = ~vsync_q & vsync_d;
    assign href_rise  = href_q & ~href_d;
    assign href_fall  = ~href_q & href_d;

    always_ff @(posedge CLK_CAM_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_n   = state_q;
        cap_entry = 1'b0;
        cap_exit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ENABLE_I) state_n = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (!ENABLE_I) begin
                    state_n = IDLE;
                end else if (vsync_fall) begin
                    state_n   = CAPTURE;
                    cap_entry = 1'b1;
                end
            end
            CAPTURE: begin
                // Enable is only consulted at frame end, so dropping it never truncates a frame.
                if (vsync_rise) begin
                    cap_exit = 1'b1;
                    state_n  = ENABLE_I ? WAIT_FRAME : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        cur_phase = href_rise ? 1'b0 : phase_q;
`ifdef CAPTURE_DECIMATE_EN
        keep_sel  = ~pix_cnt_q[0] & ~line_cnt_q[0];
`else
        keep_sel  = 1'b1;
`endif
        // A VSYNC rise ends the frame in the same cycle, so it suppresses any coincident write.
        do_write  = (state_q == CAPTURE) && !vsync_rise && href_q && cur_phase && keep_sel
                    && (pix_cnt_q < PIX_LIM) && (line_cnt_q < LINE_LIM);
    end

    always_ff @(posedge CLK_CAM_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            addr_q       <= '0;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            phase_q      <= 1'b0;
            red_q        <= 4'h0;
            WR_EN_O      <= 1'b0;
            WR_ADDR_O    <= '0;
            WR_DATA_O    <= 12'h000;
            FRAME_DONE_O <= 1'b0;
        end else begin
            WR_EN_O      <= do_write;
            FRAME_DONE_O <= cap_exit;
            if (do_write) begin
                WR_ADDR_O <= addr_q;
                WR_DATA_O <= {red_q, data_q};
                addr_q    <= addr_q + ADDR_W'(1);
            end
            if (cap_entry) begin
                addr_q     <= '0;
                pix_cnt_q  <= '0;
                line_cnt_q <= '0;
                phase_q    <= 1'b0;
            end else if (state_q == CAPTURE && !vsync_rise) begin
                if (href_q) begin
                    phase_q <= ~cur_phase;
                    if (href_rise) begin
                        pix_cnt_q <= '0;
                    end else if (cur_phase && pix_cnt_q != '1) begin
                        pix_cnt_q <= pix_cnt_q + PIX_W'(1);
                    end
                    // Phase-0 byte carries R in its low nibble; the upper nibble is padding.
                    if (!cur_phase) red_q <= data_q[3:0];
                end else if (href_fall && line_cnt_q != '1) begin
                    line_cnt_q <= line_cnt_q + LINE_W'(1);
                end
            end
        end
    end

    assign BUSY_O = (state_q == CAPTURE);

endmodule
